// File: rtl/viterbi_ber_checker.sv
// Reference-bit FIFO and error counters beside the Viterbi decoder.
// Optional burst tracking: define BER_BURST_EN to add burst_max_o.
module viterbi_ber_checker #(
  parameter int DEPTH    = 64,
  parameter int CNT_W    = 16,
  parameter int SKIP     = 16,
  parameter int NUM_BITS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             ref_valid_i,
  input  logic             ref_bit_i,
  input  logic             sym_valid_i,
  input  logic [1:0]       sym_tx_i,
  input  logic [1:0]       sym_rx_i,
  input  logic             dec_valid_i,
  input  logic             dec_bit_i,
  output logic [CNT_W-1:0] chan_err_ct_o,
  output logic [CNT_W-1:0] bit_err_ct_o,
  output logic [CNT_W-1:0] bits_chk_o,
  output logic             err_pulse_o,
  output logic             done_o,
  output logic             ovf_o,
`ifdef BER_BURST_EN
  output logic             unf_o,
  output logic [CNT_W-1:0] burst_max_o
`else
  output logic             unf_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP - 1);
  localparam logic [CNT_W-1:0] NUM_LAST = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_SKIP, S_CHECK, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           w_arm;
  logic             r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [CNT_W-1:0] r_skip_ct;
  logic [CNT_W-1:0] r_chan;
  logic [CNT_W-1:0] r_berr;
  logic [CNT_W-1:0] r_bits;
  logic             r_pulse;
  logic             r_ovf;
  logic             r_unf;

  logic             w_run;
  logic             w_empty;
  logic             w_full;
  logic             w_push_req;
  logic             w_pop_req;
  logic             w_push;
  logic             w_pop;
  logic             w_head;
  logic             w_cmp;
  logic             w_miss;
  logic             w_skip_end;
  logic             w_chk_end;
  logic             w_chan_en;
  logic [1:0]       w_x;
  logic [1:0]       w_flips;
  logic [CNT_W:0]   w_chan_sum;

  assign w_arm      = (SKIP == 0) ? S_CHECK : S_SKIP;
  assign w_run      = (r_state != S_IDLE) && !start_i;
  assign w_empty    = (r_wr == r_rd);
  assign w_full     = (r_wr[AW] != r_rd[AW]) &&
                      (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push_req = w_run && ref_valid_i;
  assign w_pop_req  = w_run && dec_valid_i;
  assign w_pop      = w_pop_req && !w_empty;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_head     = r_mem[r_rd[AW-1:0]];
  assign w_cmp      = w_pop && (r_state == S_CHECK);
  assign w_miss     = w_cmp && (dec_bit_i != w_head);
  assign w_skip_end = w_pop && (r_state == S_SKIP) &&
                      (r_skip_ct == SKIP_LAST);
  assign w_chk_end  = w_cmp && (r_bits == NUM_LAST);
  assign w_chan_en  = w_run && sym_valid_i &&
                      (r_state == S_SKIP || r_state == S_CHECK);
  assign w_x        = sym_tx_i ^ sym_rx_i;
  assign w_flips    = {1'b0, w_x[0]} + {1'b0, w_x[1]};
  assign w_chan_sum = {1'b0, r_chan} + (CNT_W+1)'(w_flips);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: start wins, else advance on warm-up / compare totals
  always_comb begin
    w_next = r_state;
    if (start_i) begin
      w_next = w_arm;
    end else begin
      unique case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_SKIP:  if (w_skip_end) w_next = S_CHECK;
        S_CHECK: if (w_chk_end) w_next = S_DONE;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    done_o = (r_state == S_DONE);
  end

  // Reference storage; contents are only read behind valid pointers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= ref_bit_i;
  end

  // Pointers, counters and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_skip_ct <= '0;
      r_chan    <= '0;
      r_berr    <= '0;
      r_bits    <= '0;
      r_pulse   <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else if (start_i) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_skip_ct <= '0;
      r_chan    <= '0;
      r_berr    <= '0;
      r_bits    <= '0;
      r_pulse   <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_pulse <= w_miss;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_pop_req && w_empty) r_unf <= 1'b1;
      if (w_pop && r_state == S_SKIP) r_skip_ct <= r_skip_ct + 1'b1;
      if (w_cmp && r_bits != CMAX) r_bits <= r_bits + 1'b1;
      if (w_miss && r_berr != CMAX) r_berr <= r_berr + 1'b1;
      if (w_chan_en) begin
        r_chan <= w_chan_sum[CNT_W] ? CMAX : w_chan_sum[CNT_W-1:0];
      end
    end
  end

  assign chan_err_ct_o = r_chan;
  assign bit_err_ct_o  = r_berr;
  assign bits_chk_o    = r_bits;
  assign err_pulse_o   = r_pulse;
  assign ovf_o         = r_ovf;
  assign unf_o         = r_unf;

`ifdef BER_BURST_EN
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_bmax;
  logic [CNT_W-1:0] w_run_nx;

  assign w_run_nx = (r_run == CMAX) ? CMAX : r_run + 1'b1;

  // Longest streak of consecutive mismatching compares
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run  <= '0;
      r_bmax <= '0;
    end else if (start_i) begin
      r_run  <= '0;
      r_bmax <= '0;
    end else if (w_cmp) begin
      if (w_miss) begin
        r_run <= w_run_nx;
        if (w_run_nx > r_bmax) r_bmax <= w_run_nx;
      end else begin
        r_run <= '0;
      end
    end
  end

  assign burst_max_o = r_bmax;
`endif

endmodule
